// File: rtl/snake_step_ctrl.sv
// Game-step sequencer: divides clk into move steps, commits direction, advances the
// wrapping head coordinate, tracks length and runs the IDLE/RUN/PAUSE/DEAD state machine.
module snake_step_ctrl #(
    parameter int TICK_DIV = 12_500_000,
    parameter int GRID_W   = 16,
    parameter int GRID_H   = 16,
    parameter int START_X  = 8,
    parameter int START_Y  = 8,
    parameter int INIT_LEN = 3,
    parameter int MAX_LEN  = 15
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [1:0]                     s_dir,
    input  logic                           start,
    input  logic                           pause,
    input  logic                           eat,
    input  logic                           body_hit,
    output logic                           step,
    output logic [$clog2(GRID_W)-1:0]      head_x,
    output logic [$clog2(GRID_H)-1:0]      head_y,
    output logic [1:0]                     cur_dir,
    output logic [$clog2(MAX_LEN+1)-1:0]   length,
    output logic                           running,
    output logic                           dead
);

    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE, ST_DEAD} state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   head_x_q, head_x_d;
    logic [YW-1:0]   head_y_q, head_y_d;
    logic [1:0]      cur_dir_q, cur_dir_d;
    logic [LW-1:0]   length_q, length_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            grow_q, grow_d;
    logic            step_q, step_d;

    logic            init;
    logic            at_last;
    logic            step_evt;
    logic [1:0]      new_dir;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a collision outranks a pause request
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN: begin
                if (body_hit)   state_d = ST_DEAD;
                else if (pause) state_d = ST_PAUSE;
            end
            ST_PAUSE: if (!pause) state_d = ST_RUN;
            ST_DEAD:  if (start) state_d = ST_RUN;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        running = (state_q == ST_RUN);
        dead    = (state_q == ST_DEAD);
        step    = step_q;
        head_x  = head_x_q;
        head_y  = head_y_q;
        cur_dir = cur_dir_q;
        length  = length_q;
    end

    assign init     = ((state_q == ST_IDLE) || (state_q == ST_DEAD)) && start;
    assign at_last  = (cnt_q == CNT_LAST);
    assign step_evt = (state_q == ST_RUN) && at_last && !body_hit && !pause;
    // The bitwise complement of a direction code is its exact opposite
    assign new_dir  = (s_dir == ~cur_dir_q) ? cur_dir_q : s_dir;

    always_comb begin
        head_x_d  = head_x_q;
        head_y_d  = head_y_q;
        cur_dir_d = cur_dir_q;
        length_d  = length_q;
        cnt_d     = cnt_q;
        grow_d    = grow_q;
        step_d    = 1'b0;
        if (init) begin
            head_x_d  = XW'(START_X);
            head_y_d  = YW'(START_Y);
            cur_dir_d = 2'b00;
            length_d  = LW'(INIT_LEN);
            cnt_d     = '0;
            grow_d    = 1'b0;
        end else begin
            if (state_q == ST_RUN) begin
                cnt_d = at_last ? '0 : cnt_q + CW'(1);
            end
            if (step_evt) begin
                step_d    = 1'b1;
                cur_dir_d = new_dir;
                case (new_dir)
                    2'b00:   head_y_d = head_y_q - YW'(1);
                    2'b01:   head_x_d = head_x_q - XW'(1);
                    2'b10:   head_x_d = head_x_q + XW'(1);
                    default: head_y_d = head_y_q + YW'(1);
                endcase
                if (grow_q || eat) begin
                    if (length_q < LW'(MAX_LEN)) length_d = length_q + LW'(1);
                    grow_d = 1'b0;
                end
            end else if (eat && ((state_q == ST_RUN) || (state_q == ST_PAUSE))) begin
                grow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_x_q  <= XW'(START_X);
            head_y_q  <= YW'(START_Y);
            cur_dir_q <= 2'b00;
            length_q  <= LW'(INIT_LEN);
            cnt_q     <= '0;
            grow_q    <= 1'b0;
            step_q    <= 1'b0;
        end else begin
            head_x_q  <= head_x_d;
            head_y_q  <= head_y_d;
            cur_dir_q <= cur_dir_d;
            length_q  <= length_d;
            cnt_q     <= cnt_d;
            grow_q    <= grow_d;
            step_q    <= step_d;
        end
    end

endmodule

// File: tb/tb_snake_step_ctrl.sv
// Directed bench for snake_step_ctrl on a 4x4 grid with a 4-cycle step period.
module tb_snake_step_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       eat = 1'b0;
    logic       body_hit = 1'b0;
    logic [1:0] s_dir = 2'b00;
    logic       step;
    logic [1:0] head_x, head_y, cur_dir;
    logic [2:0] length;
    logic       running, dead;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic       rst, st, pa, ea, hit;
        logic [1:0] sd;
        logic       estep;
        logic [1:0] ex, ey, ed;
        logic [2:0] el;
        logic       erun, edead;
    } vec_t;

    vec_t vq[$];

    snake_step_ctrl #(
        .TICK_DIV(4), .GRID_W(4), .GRID_H(4), .START_X(2), .START_Y(2),
        .INIT_LEN(3), .MAX_LEN(5)
    ) dut (
        .clk(clk), .reset(reset), .s_dir(s_dir), .start(start), .pause(pause),
        .eat(eat), .body_hit(body_hit), .step(step), .head_x(head_x), .head_y(head_y),
        .cur_dir(cur_dir), .length(length), .running(running), .dead(dead)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    task automatic check_all(input string name, input logic estep, input logic [1:0] ex,
                             input logic [1:0] ey, input logic [1:0] ed, input logic [2:0] el,
                             input logic erun, input logic edead);
        logic [11:0] act, exp;
        act = {step, head_x, head_y, cur_dir, length, running, dead};
        exp = {estep, ex, ey, ed, el, erun, edead};
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got step=%b x=%0d y=%0d dir=%b len=%0d run=%b dead=%b, want step=%b x=%0d y=%0d dir=%b len=%0d run=%b dead=%b",
                      name, step, head_x, head_y, cur_dir, length, running, dead,
                      estep, ex, ey, ed, el, erun, edead);
    endtask

    task automatic push(input logic rst, input logic st, input logic pa, input logic ea,
                        input logic hit, input logic [1:0] sd, input logic estep,
                        input logic [1:0] ex, input logic [1:0] ey, input logic [1:0] ed,
                        input logic [2:0] el, input logic erun, input logic edead);
        vec_t v;
        v.rst = rst; v.st = st; v.pa = pa; v.ea = ea; v.hit = hit; v.sd = sd;
        v.estep = estep; v.ex = ex; v.ey = ey; v.ed = ed; v.el = el;
        v.erun = erun; v.edead = edead;
        vq.push_back(v);
    endtask

    // One step period in RUN: three quiet cycles driving a decoy s_dir, then the terminal cycle.
    task automatic interval(input logic [1:0] noise, input logic [1:0] tc_dir,
                            input logic eat_mid, input logic eat_tc,
                            input logic [1:0] px, input logic [1:0] py, input logic [1:0] pd,
                            input logic [2:0] pl, input logic [1:0] nx, input logic [1:0] ny,
                            input logic [1:0] nd, input logic [2:0] nl);
        push(0, 0, 0, 0,       0, noise,  0, px, py, pd, pl, 1, 0);
        push(0, 0, 0, eat_mid, 0, noise,  0, px, py, pd, pl, 1, 0);
        push(0, 0, 0, 0,       0, noise,  0, px, py, pd, pl, 1, 0);
        push(0, 0, 0, eat_tc,  0, tc_dir, 1, nx, ny, nd, nl, 1, 0);
    endtask

    initial begin
        int steps_seen;
        int cnt;
        int total_edges;

        push(1, 0, 0, 0, 0, 2'b00, 0, 2, 2, 0, 3, 0, 0);
        push(0, 0, 0, 1, 0, 2'b00, 0, 2, 2, 0, 3, 0, 0);
        push(0, 1, 0, 0, 0, 2'b00, 0, 2, 2, 0, 3, 1, 0);
        interval(2'b00, 2'b00, 0, 0, 2, 2, 0, 3, 2, 1, 0, 3);
        interval(2'b00, 2'b00, 0, 0, 2, 1, 0, 3, 2, 0, 0, 3);
        interval(2'b00, 2'b00, 0, 0, 2, 0, 0, 3, 2, 3, 0, 3);
        interval(2'b01, 2'b11, 0, 0, 2, 3, 0, 3, 2, 2, 0, 3);
        interval(2'b11, 2'b01, 0, 0, 2, 2, 0, 3, 1, 2, 1, 3);
        interval(2'b00, 2'b10, 0, 0, 1, 2, 1, 3, 0, 2, 1, 3);
        interval(2'b10, 2'b10, 0, 0, 0, 2, 1, 3, 3, 2, 1, 3);
        interval(2'b01, 2'b01, 1, 0, 3, 2, 1, 3, 2, 2, 1, 4);
        interval(2'b01, 2'b01, 0, 1, 2, 2, 1, 4, 1, 2, 1, 5);
        interval(2'b01, 2'b01, 0, 1, 1, 2, 1, 5, 0, 2, 1, 5);

        for (int i = 0; i < vq.size(); i++) begin
            reset = vq[i].rst; start = vq[i].st; pause = vq[i].pa;
            eat = vq[i].ea; body_hit = vq[i].hit; s_dir = vq[i].sd;
            tick();
            $display("row %0d: step=%b x=%0d y=%0d dir=%b len=%0d run=%b dead=%b",
                     i, step, head_x, head_y, cur_dir, length, running, dead);
            check_all($sformatf("row%0d", i), vq[i].estep, vq[i].ex, vq[i].ey, vq[i].ed,
                      vq[i].el, vq[i].erun, vq[i].edead);
        end
        start = 0; eat = 0; body_hit = 0; pause = 0; s_dir = 2'b01;

        // Pause for 10 cycles starting with the counter at 1
        tick();
        pause = 1;
        steps_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (step) steps_seen++;
        end
        $display("pause window: steps=%0d run=%b x=%0d", steps_seen, running, head_x);
        check("pause_no_step", steps_seen, 0);
        check("pause_not_running", running, 0);
        check("pause_head_frozen", head_x, 0);
        pause = 0;
        cnt = 0;
        while (!running && cnt < 6) begin
            tick();
            cnt++;
        end
        total_edges = 10 + cnt;
        check("pause_release_latency", cnt, 1);
        cnt = 0;
        while (!step && cnt < 8) begin
            tick();
            cnt++;
        end
        total_edges += cnt;
        $display("pause release: step after %0d cycles of RUN, total delay %0d", cnt, total_edges);
        check("pause_step_after_resume", cnt, 2);
        check("pause_total_delay", total_edges, 3 + 10);
        check_all("pause_step_values", 1, 3, 2, 1, 5, 1, 0);

        // Collision in the terminal-count cycle
        tick(); tick(); tick();
        check_all("pre_hit", 0, 3, 2, 1, 5, 1, 0);
        body_hit = 1;
        tick();
        body_hit = 0;
        $display("collision: step=%b x=%0d dead=%b run=%b", step, head_x, dead, running);
        check_all("hit_dead", 0, 3, 2, 1, 5, 0, 1);
        eat = 1; tick(); eat = 0; tick();
        check_all("dead_hold", 0, 3, 2, 1, 5, 0, 1);
        start = 1; s_dir = 2'b00;
        tick();
        start = 0;
        $display("restart: x=%0d y=%0d len=%0d dir=%b run=%b", head_x, head_y, length, cur_dir, running);
        check_all("restart_init", 0, 2, 2, 0, 3, 1, 0);
        cnt = 0;
        while (!step && cnt < 8) begin
            tick();
            cnt++;
        end
        $display("restart: first step after %0d cycles", cnt);
        check("restart_first_step", cnt, 4);
        check_all("restart_step_values", 1, 2, 1, 0, 3, 1, 0);

        // Reset mid-run overrides start and eat
        tick(); tick();
        reset = 1; start = 1; eat = 1;
        tick();
        $display("reset: step=%b x=%0d y=%0d len=%0d run=%b", step, head_x, head_y, length, running);
        check_all("reset_mid_run", 0, 2, 2, 0, 3, 0, 0);
        reset = 0; start = 0; eat = 0;
        steps_seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (step || running) steps_seen++;
        end
        check("reset_stays_idle", steps_seen, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
